// File: rtl/attitude_frame_pkg.sv
// rtl/attitude_frame_pkg.sv - shared states, frame constants and CRC-8 step for the attitude frame source
package attitude_frame_pkg;

    localparam int         FRAME_LEN = 8;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    // Encodings equal the byte index, so the index output is the state itself.
    typedef enum logic [2:0] {
        S_SYNC0   = 3'd0,
        S_SYNC1   = 3'd1,
        S_SEQ     = 3'd2,
        S_ROLL_H  = 3'd3,
        S_ROLL_L  = 3'd4,
        S_PITCH_H = 3'd5,
        S_PITCH_L = 3'd6,
        S_CSUM    = 3'd7
    } state_e;

    localparam logic [2:0] IDX_SYNC0   = 3'd0;
    localparam logic [2:0] IDX_SYNC1   = 3'd1;
    localparam logic [2:0] IDX_SEQ     = 3'd2;
    localparam logic [2:0] IDX_ROLL_H  = 3'd3;
    localparam logic [2:0] IDX_ROLL_L  = 3'd4;
    localparam logic [2:0] IDX_PITCH_H = 3'd5;
    localparam logic [2:0] IDX_PITCH_L = 3'd6;
    localparam logic [2:0] IDX_CSUM    = 3'd7;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/attitude_frame_tx_if.sv
// rtl/attitude_frame_tx_if.sv - sample input, transmitter handshake and byte output bundle
interface attitude_frame_tx_if;
    logic [15:0] i_roll;
    logic [15:0] i_pitch;
    logic        i_data_valid;
    logic        i_tx_done;
    logic [7:0]  o_tx_byte;
    logic        o_frame_start;
    logic [2:0]  o_byte_index;

    modport master (
        output i_roll, i_pitch, i_data_valid, i_tx_done,
        input  o_tx_byte, o_frame_start, o_byte_index
    );

    modport slave (
        input  i_roll, i_pitch, i_data_valid, i_tx_done,
        output o_tx_byte, o_frame_start, o_byte_index
    );
endinterface

// File: rtl/attitude_frame_check.sv
// rtl/attitude_frame_check.sv - frame check byte; additive mod-256 sum, or CRC-8 when ATT_FRAME_CRC_EN is defined
module attitude_frame_check
    import attitude_frame_pkg::*;
(
    input  logic [7:0] seq_i,
    input  logic [7:0] roll_h_i,
    input  logic [7:0] roll_l_i,
    input  logic [7:0] pitch_h_i,
    input  logic [7:0] pitch_l_i,
    output logic [7:0] check_o
);

`ifdef ATT_FRAME_CRC_EN
    // CRC runs over the payload in transmit order, seed zero.
    always_comb begin
        check_o = 8'h00;
        check_o = crc8_byte(check_o, seq_i);
        check_o = crc8_byte(check_o, roll_h_i);
        check_o = crc8_byte(check_o, roll_l_i);
        check_o = crc8_byte(check_o, pitch_h_i);
        check_o = crc8_byte(check_o, pitch_l_i);
    end
`else
    assign check_o = seq_i + roll_h_i + roll_l_i + pitch_h_i + pitch_l_i;
`endif

endmodule

// File: rtl/attitude_frame_tx.sv
// rtl/attitude_frame_tx.sv - packs roll/pitch into an 8-byte frame and steps one byte per transmitter done pulse
module attitude_frame_tx
    import attitude_frame_pkg::*;
#(
    parameter logic [7:0] SYNC0 = 8'hAA,
    parameter logic [7:0] SYNC1 = 8'h55
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    attitude_frame_tx_if.slave bus
);

    state_e      state_q;
    logic [7:0]  seq_q;
    logic [15:0] shadow_roll_q, shadow_pitch_q;
    logic [15:0] snap_roll_q, snap_pitch_q;
    logic [7:0]  tx_byte_q;
    logic [2:0]  byte_index_q;
    logic        frame_start_q;

    logic [2:0]  index_d;
    state_e      state_d;
    logic [7:0]  tx_byte_d;
    logic [7:0]  check_byte;

    attitude_frame_check u_check (
        .seq_i     (seq_q),
        .roll_h_i  (snap_roll_q[15:8]),
        .roll_l_i  (snap_roll_q[7:0]),
        .pitch_h_i (snap_pitch_q[15:8]),
        .pitch_l_i (snap_pitch_q[7:0]),
        .check_o   (check_byte)
    );

    assign index_d = byte_index_q + 3'd1;
    assign state_d = state_e'(index_d);

    // Payload bytes read the snapshot, which only moves when the next byte is SYNC0.
    always_comb begin
        tx_byte_d = SYNC0;
        case (state_d)
            S_SYNC0:   tx_byte_d = SYNC0;
            S_SYNC1:   tx_byte_d = SYNC1;
            S_SEQ:     tx_byte_d = seq_q;
            S_ROLL_H:  tx_byte_d = snap_roll_q[15:8];
            S_ROLL_L:  tx_byte_d = snap_roll_q[7:0];
            S_PITCH_H: tx_byte_d = snap_pitch_q[15:8];
            S_PITCH_L: tx_byte_d = snap_pitch_q[7:0];
            S_CSUM:    tx_byte_d = check_byte;
            default:   tx_byte_d = SYNC0;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q        <= S_SYNC0;
            seq_q          <= 8'h00;
            shadow_roll_q  <= 16'h0000;
            shadow_pitch_q <= 16'h0000;
            snap_roll_q    <= 16'h0000;
            snap_pitch_q   <= 16'h0000;
            tx_byte_q      <= SYNC0;
            byte_index_q   <= IDX_SYNC0;
            frame_start_q  <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (bus.i_data_valid) begin
                shadow_roll_q  <= bus.i_roll;
                shadow_pitch_q <= bus.i_pitch;
            end
            if (bus.i_tx_done) begin
                state_q      <= state_d;
                tx_byte_q    <= tx_byte_d;
                byte_index_q <= index_d;
                if (state_q == S_CSUM) begin
                    frame_start_q <= 1'b1;
                    seq_q         <= seq_q + 8'd1;
                    // A strobe landing on the wrap edge bypasses the shadow.
                    snap_roll_q   <= bus.i_data_valid ? bus.i_roll  : shadow_roll_q;
                    snap_pitch_q  <= bus.i_data_valid ? bus.i_pitch : shadow_pitch_q;
                end
            end
        end
    end

    assign bus.o_tx_byte     = tx_byte_q;
    assign bus.o_byte_index  = byte_index_q;
    assign bus.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_attitude_frame_tx.sv
// tb/tb_attitude_frame_tx.sv - scoreboard bench for attitude_frame_tx
module tb_attitude_frame_tx;

    logic clk;
    logic rst_n;
    attitude_frame_tx_if bus();

    attitude_frame_tx dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec;
    int nfail;
    logic [7:0]  exp_q[$];
    logic [7:0]  m_seq;
    logic [15:0] m_shadow_r, m_shadow_p, m_snap_r, m_snap_p;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_check(input logic [7:0] s, input logic [15:0] r, input logic [15:0] p);
        logic [39:0] bits;
        logic [7:0]  crc;
        logic        fb;
`ifdef ATT_FRAME_CRC_EN
        bits = {s, r, p};
        crc  = 8'h00;
        for (int k = 39; k >= 0; k--) begin
            fb  = crc[7] ^ bits[k];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return crc;
`else
        bits = 40'd0;
        fb   = 1'b0;
        crc  = s + r[15:8] + r[7:0] + p[15:8] + p[7:0];
        return crc + bits[7:0] + {7'd0, fb};
`endif
    endfunction

    // inj_at: -1 none, 0..7 strobe while that byte is presented, 8 strobe on the wrap edge
    task automatic do_frame(input int npulse, input int inj_at, input logic [15:0] ir, input logic [15:0] ip);
        logic [7:0] f[8];
        logic [7:0] e;
        f[0] = 8'hAA; f[1] = 8'h55; f[2] = m_seq;
        f[3] = m_snap_r[15:8]; f[4] = m_snap_r[7:0];
        f[5] = m_snap_p[15:8]; f[6] = m_snap_p[7:0];
        f[7] = model_check(m_seq, m_snap_r, m_snap_p);
        for (int k = 1; k < 8; k++) exp_q.push_back(f[k]);
        exp_q.push_back(8'hAA);
        for (int i = 0; i < npulse; i++) begin
            if (inj_at == i) begin
                @(negedge clk);
                bus.i_data_valid = 1'b1; bus.i_roll = ir; bus.i_pitch = ip;
                @(negedge clk);
                bus.i_data_valid = 1'b0;
                m_shadow_r = ir; m_shadow_p = ip;
            end
            @(negedge clk);
            bus.i_tx_done = 1'b1;
            if (i == 7 && inj_at == 8) begin
                bus.i_data_valid = 1'b1; bus.i_roll = ir; bus.i_pitch = ip;
            end
            @(negedge clk);
            bus.i_tx_done = 1'b0;
            bus.i_data_valid = 1'b0;
            if (i == 7) begin
                if (inj_at == 8) begin
                    m_shadow_r = ir; m_shadow_p = ip;
                end
                m_snap_r = m_shadow_r; m_snap_p = m_shadow_p;
                m_seq = m_seq + 8'd1;
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk("tx_byte", {24'd0, bus.o_tx_byte}, {24'd0, e});
            chk("byte_index", {29'd0, bus.o_byte_index}, 32'((i + 1) % 8));
            chk("frame_start", {31'd0, bus.o_frame_start}, {31'd0, (i == 7)});
            @(negedge clk);
            chk("tx_byte_hold", {24'd0, bus.o_tx_byte}, {24'd0, e});
        end
    endtask

    task automatic model_reset();
        m_seq = 8'h00;
        m_shadow_r = 16'h0; m_shadow_p = 16'h0;
        m_snap_r = 16'h0; m_snap_p = 16'h0;
        exp_q.delete();
    endtask

    initial begin
        nvec = 0;
        nfail = 0;
        rst_n = 1'b0;
        bus.i_roll = 16'h0; bus.i_pitch = 16'h0;
        bus.i_data_valid = 1'b0; bus.i_tx_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_tx_byte", {24'd0, bus.o_tx_byte}, 32'hAA);
        chk("rst_byte_index", {29'd0, bus.o_byte_index}, 32'd0);
        chk("rst_frame_start", {31'd0, bus.o_frame_start}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_exit_frame_start", {31'd0, bus.o_frame_start}, 32'd0);
        chk("rst_exit_tx_byte", {24'd0, bus.o_tx_byte}, 32'hAA);

        // frame 0 zeros, strobe 1234/FEDC during it
        do_frame(8, 3, 16'h1234, 16'hFEDC);
        // frame 1 carries 1234/FEDC; strobe 8000/7FFF on the wrap edge
        do_frame(8, 8, 16'h8000, 16'h7FFF);
        // frame 2 carries 8000/7FFF; new data at byte 4 must not leak in
        do_frame(8, 4, 16'h0BAD, 16'hC0DE);
        do_frame(8, -1, 16'h0, 16'h0);

        for (int n = 0; n < 256; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9)) - 1;
            do_frame(8, sel, 16'($urandom), 16'($urandom));
        end

        // async reset while presenting byte 5
        do_frame(5, 1, 16'h4321, 16'h8765);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx_byte", {24'd0, bus.o_tx_byte}, 32'hAA);
        chk("async_rst_byte_index", {29'd0, bus.o_byte_index}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_frame(8, -1, 16'h0, 16'h0);
        do_frame(8, -1, 16'h0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
